// File: rtl/ip_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ip_demux_pkg : shared FSM type, IPv4 constants and helpers          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package ip_demux_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FLUSH = 3'd2,
    PASS  = 3'd3,
    DROP  = 3'd4
  } state_e;

  localparam logic [3:0] IP_VER_V4 = 4'd4;
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam int         HDR_WORDS = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_hdr_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ip_hdr_buf : 3-entry header store (data + last) with write/read     |
// | indices and a synchronous discard. Rev 1.0                          |
// +--------------------------------------------------------------------+
module ip_hdr_buf
  import ip_demux_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_last_i,
  input  logic        rd_adv_i,
  output logic [31:0] rd_data_o,
  output logic        rd_last_o,
  output logic [3:0]  ver_o,
  output logic [1:0]  wr_idx_o,
  output logic [1:0]  rd_idx_o
);

  localparam logic [1:0] LAST_IDX = 2'(HDR_WORDS - 1);

  logic [32:0] mem_q [HDR_WORDS];
  logic [1:0]  wr_idx_q;
  logic [1:0]  rd_idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HDR_WORDS; i++) mem_q[i] <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < HDR_WORDS; i++) mem_q[i] <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_en_i && (wr_idx_q <= LAST_IDX)) begin
        mem_q[wr_idx_q] <= {wr_last_i, wr_data_i};
        wr_idx_q        <= wr_idx_q + 2'd1;
      end
      // Read index parks on the last entry; the owner clears after it drains.
      if (rd_adv_i && (rd_idx_q < LAST_IDX)) begin
        rd_idx_q <= rd_idx_q + 2'd1;
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_q][31:0];
  assign rd_last_o = mem_q[rd_idx_q][32];
  assign ver_o     = mem_q[0][31:28];
  assign wr_idx_o  = wr_idx_q;
  assign rd_idx_o  = rd_idx_q;

endmodule
`default_nettype wire

// File: rtl/ip_proto_demux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ip_proto_demux : routes IPv4 packets to a channel by protocol field |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ip_proto_demux
  import ip_demux_pkg::*;
#(
  parameter int                N_CH         = 2,
  parameter logic [8*N_CH-1:0] PROTO_MAP    = {PROTO_UDP, PROTO_TCP},
  parameter int                UNKNOWN_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ip_data_in,
  input  logic               ip_data_valid,
  input  logic               ip_data_last,
  output logic               ip_data_ready,
  output logic [32*N_CH-1:0] out_data,
  output logic [N_CH-1:0]    out_valid,
  output logic [N_CH-1:0]    out_last,
  input  logic [N_CH-1:0]    out_ready,
  output logic [15:0]        drop_count
);

  localparam logic [1:0] LAST_CH  = 2'(N_CH - 1);
  localparam logic [1:0] WORD2_IX = 2'(HDR_WORDS - 1);

  state_e      state_q;
  logic [1:0]  sel_q;
  logic [15:0] drop_cnt_q;

  logic        w_acc;
  logic        w_buf_wr;
  logic        w_buf_clr;
  logic        w_flush_hs;
  logic        w_drop_now;
  logic        w_route;
  logic        w_hit;
  logic [1:0]  w_hit_ch;
  logic [1:0]  w_route_ch;
  logic        w_valid;
  logic        w_last;
  logic [31:0] w_data;
  logic [31:0] w_rd_data;
  logic        w_rd_last;
  logic [3:0]  w_ver;
  logic [1:0]  w_wr_idx;
  logic [1:0]  w_rd_idx;

  // Lowest-index match wins, so scan downwards and let later hits overwrite.
  function automatic logic [2:0] lookup(input logic [7:0] proto);
    logic       hit;
    logic [1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (PROTO_MAP[8*i +: 8] == proto) begin
        hit = 1'b1;
        idx = i[1:0];
      end
    end
    return {hit, idx};
  endfunction

  ip_hdr_buf u_hdr_buf (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (w_buf_clr),
    .wr_en_i   (w_buf_wr),
    .wr_data_i (ip_data_in),
    .wr_last_i (ip_data_last),
    .rd_adv_i  (w_flush_hs),
    .rd_data_o (w_rd_data),
    .rd_last_o (w_rd_last),
    .ver_o     (w_ver),
    .wr_idx_o  (w_wr_idx),
    .rd_idx_o  (w_rd_idx)
  );

  always_comb begin
    ip_data_ready = 1'b0;
    case (state_q)
      IDLE, HDR, DROP: ip_data_ready = 1'b1;
      PASS:            ip_data_ready = out_ready[sel_q];
      default:         ip_data_ready = 1'b0;
    endcase
    ip_data_ready = ip_data_ready & ~reset;
  end

  always_comb begin
    {w_hit, w_hit_ch} = lookup(ip_data_in[23:16]);
    w_route    = (w_ver == IP_VER_V4) && (w_hit || (UNKNOWN_MODE != 0));
    w_route_ch = w_hit ? w_hit_ch : LAST_CH;
  end

  assign w_acc      = ip_data_valid & ip_data_ready;
  assign w_buf_wr   = w_acc && ((state_q == IDLE) || (state_q == HDR));
  assign w_flush_hs = (state_q == FLUSH) && out_ready[sel_q];
  // Short packets (last on word 0/1) and rejected headers both count as drops.
  assign w_drop_now = w_buf_wr &&
                      ((w_wr_idx == WORD2_IX) ? !w_route : ip_data_last);
  assign w_buf_clr  = w_drop_now || (w_flush_hs && (w_rd_idx == WORD2_IX));

  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = w_rd_data;
    case (state_q)
      FLUSH: begin
        w_valid = 1'b1;
        w_last  = w_rd_last && (w_rd_idx == WORD2_IX);
      end
      PASS: begin
        w_valid = ip_data_valid;
        w_last  = ip_data_last;
        w_data  = ip_data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (w_drop_now) drop_cnt_q <= sat_inc16(drop_cnt_q);
      case (state_q)
        IDLE, HDR: begin
          if (w_acc) begin
            if (w_wr_idx == WORD2_IX) begin
              if (w_route) begin
                sel_q   <= w_route_ch;
                state_q <= FLUSH;
              end else begin
                state_q <= ip_data_last ? IDLE : DROP;
              end
            end else begin
              state_q <= ip_data_last ? IDLE : HDR;
            end
          end
        end
        FLUSH: begin
          if (w_flush_hs && (w_rd_idx == WORD2_IX)) begin
            state_q <= w_rd_last ? IDLE : PASS;
          end
        end
        PASS, DROP: begin
          if (w_acc && ip_data_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign out_data[32*i +: 32] = w_data;
      assign out_valid[i]         = w_valid && (sel_q == 2'(i));
      assign out_last[i]          = w_last && (sel_q == 2'(i));
    end
  endgenerate

  assign drop_count = drop_cnt_q;

endmodule
`default_nettype wire
